// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile
// APB slave that fronts a 64 x 32-bit register file. It supports byte-lane write
// strobes and registered PRDATA/PREADY/PSLVERR. Address, control, data and strobes
// are captured when a transfer enters SETUP, so bus changes during ACCESS have no
// effect on the transfer.
//
// Build option:
//   APB_SLAVE_WAIT_EN  defined   -> each transfer inserts WAIT_CYCLES low-PREADY ACCESS
//                                   cycles, counted by a small down-counter.
//                      undefined -> no counter is built, WAIT_CYCLES is ignored, and
//                                   PREADY is high in the first ACCESS cycle.

module apb_slave_regfile #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        PCLK,
    input  logic        PRESET_n,
    input  logic        PSELx,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e      state_q;

    // Transfer attributes captured when entering SETUP
    logic [5:0]  idx_q;
    logic        write_q;
    logic        err_q;
    logic [31:0] wdata_q;
    logic [3:0]  strb_q;

    // Registered bus outputs
    logic [31:0] prdata_q;
    logic        pready_q;
    logic        pslverr_q;

`ifdef APB_SLAVE_WAIT_EN
    logic [3:0]  wait_cnt_q;
`endif

    // Combinational helpers
    logic        err_d;
    logic        wr_en_d;
    logic [31:0] rd_data_d;
    logic [31:0] rd_word [64];

    // An error is a misaligned address, or a read that carries write strobes
    assign err_d = (PADDR[1:0] != 2'b00) || (!PWRITE && (PSTRB != 4'h0));

    // Memory updates only on the completing edge of a clean write
    assign wr_en_d = (state_q == ST_ACCESS) && pready_q && PSELx && PENABLE
                     && write_q && !err_q;

    // Read data is presented only for clean reads and is zero in all other cases
    assign rd_data_d = (write_q || err_q) ? 32'h0 : rd_word[idx_q];

    // Register file: one word register per address, byte-lane merged on write
    genvar gi;
    genvar gj;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_word
            logic [31:0] word_q;
            logic [31:0] word_d;

            for (gj = 0; gj < 4; gj++) begin : g_lane
                assign word_d[8*gj +: 8] = strb_q[gj] ? wdata_q[8*gj +: 8]
                                                      : word_q[8*gj +: 8];
            end

            // Word storage, cleared by reset and written at transfer completion
            always_ff @(posedge PCLK or negedge PRESET_n) begin
                if (!PRESET_n) begin
                    word_q <= 32'h0;
                end else if (wr_en_d && (idx_q == 6'(gi))) begin
                    word_q <= word_d;
                end
            end

            assign rd_word[gi] = word_q;
        end
    endgenerate

    // Transfer FSM with the registered PREADY/PSLVERR/PRDATA outputs
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= 6'h0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= 32'h0;
            strb_q     <= 4'h0;
            prdata_q   <= 32'h0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
`ifdef APB_SLAVE_WAIT_EN
            wait_cnt_q <= 4'h0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= 32'h0;
                    // A setup phase on the bus starts a transfer. This is also the
                    // back-to-back path: completion returns here, and the next setup
                    // phase is picked up on the following edge without a bubble.
                    if (PSELx && !PENABLE) begin
                        state_q <= ST_SETUP;
                        idx_q   <= PADDR[7:2];
                        write_q <= PWRITE;
                        err_q   <= err_d;
                        wdata_q <= PWDATA;
                        strb_q  <= PSTRB;
                    end
                end

                ST_SETUP: begin
                    state_q <= ST_ACCESS;
`ifdef APB_SLAVE_WAIT_EN
                    wait_cnt_q <= 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        pready_q  <= 1'b1;
                        pslverr_q <= err_q;
                        prdata_q  <= rd_data_d;
                    end
`else
                    pready_q  <= 1'b1;
                    pslverr_q <= err_q;
                    prdata_q  <= rd_data_d;
`endif
                end

                ST_ACCESS: begin
                    if (!PSELx) begin
                        // The requester withdrew: abort without writing
                        state_q   <= ST_IDLE;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                        prdata_q  <= 32'h0;
`ifdef APB_SLAVE_WAIT_EN
                        wait_cnt_q <= 4'h0;
`endif
                    end else if (pready_q) begin
                        // Completion: the write lands in the word registers on this edge
                        if (PENABLE) begin
                            state_q   <= ST_IDLE;
                            pready_q  <= 1'b0;
                            pslverr_q <= 1'b0;
                            prdata_q  <= 32'h0;
                        end
                    end
`ifdef APB_SLAVE_WAIT_EN
                    else begin
                        // Wait state: PREADY rises on the edge where the count reaches zero
                        wait_cnt_q <= wait_cnt_q - 4'h1;
                        if (wait_cnt_q == 4'h1) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= err_q;
                            prdata_q  <= rd_data_d;
                        end
                    end
`endif
                end

                default: begin
                    state_q   <= ST_IDLE;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= 32'h0;
                end
            endcase
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule
